// File: rtl/wb_timer_if.sv
// wb_timer_if
//   32-bit Wishbone slave bundle for the RISC-V machine timer.
//   master: drives the address, write data, byte selects, cyc, stb, cti, bte and we.
//   slave : drives the read data, ack and err.
//   The tmr_ prefix matches the peripheral-bus signal names used at the top level.
interface wb_timer_if;
  logic [5:0]  tmr_addr;
  logic [31:0] tmr_dat_w;
  logic [3:0]  tmr_sel;
  logic        tmr_cyc;
  logic        tmr_stb;
  logic [2:0]  tmr_cti;
  logic [1:0]  tmr_bte;
  logic        tmr_we;
  logic [31:0] tmr_dat_r;
  logic        tmr_ack;
  logic        tmr_err;

  modport master (
    output tmr_addr, tmr_dat_w, tmr_sel, tmr_cyc, tmr_stb, tmr_cti, tmr_bte, tmr_we,
    input  tmr_dat_r, tmr_ack, tmr_err
  );

  modport slave (
    input  tmr_addr, tmr_dat_w, tmr_sel, tmr_cyc, tmr_stb, tmr_cti, tmr_bte, tmr_we,
    output tmr_dat_r, tmr_ack, tmr_err
  );
endinterface

// File: rtl/wb_timer.sv
// wb_timer
//   RISC-V machine timer. It holds a free-running 64-bit mtime and a 64-bit
//   mtimecmp, and both are reachable as 32-bit halves over Wishbone.
//   timer_interrupt is a registered, level-sensitive (mtime >= mtimecmp).
// Ports
//   clk             clock
//   rst             asynchronous, active-high reset
//   bus             Wishbone slave (wb_timer_if.slave)
//                   addr[1:0] selects the register: 0 = mtime lo, 1 = mtime hi,
//                   2 = mtimecmp lo, 3 = mtimecmp hi
//   timer_interrupt machine-timer interrupt request to the core
// Parameters
//   PRESCALER       clk cycles per mtime increment, 1..65536
module wb_timer #(
  parameter int unsigned PRESCALER = 1
) (
  input  logic       clk,
  input  logic       rst,
  wb_timer_if.slave  bus,
  output logic       timer_interrupt
);

  localparam int unsigned      PRE_W   = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALER - 1);

  typedef enum logic [1:0] {
    REG_MTIME_LO = 2'd0,
    REG_MTIME_HI = 2'd1,
    REG_CMP_LO   = 2'd2,
    REG_CMP_HI   = 2'd3
  } reg_sel_e;

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [63:0]      mtime;
  logic [63:0]      mtimecmp;
  logic             req;
  logic             wr_en;
  reg_sel_e         reg_sel;
  logic [31:0]      rd_data;

  // The cycle-type fields and the upper address bits do not affect decoding.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.tmr_cti, bus.tmr_bte, bus.tmr_addr[5:2]};

  assign bus.tmr_err = 1'b0;

  assign reg_sel = reg_sel_e'(bus.tmr_addr[1:0]);
  // Excluding the cycle in which ack is high gives one wait state and one ack per request.
  assign req     = bus.tmr_cyc && bus.tmr_stb && !bus.tmr_ack;
  // Partial-select writes are acknowledged but never commit.
  assign wr_en   = req && bus.tmr_we && (bus.tmr_sel == 4'hF);
  assign tick    = (pre == PRE_MAX);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_data = 32'h0;
    unique case (reg_sel)
      REG_MTIME_LO: rd_data = mtime[31:0];
      REG_MTIME_HI: rd_data = mtime[63:32];
      REG_CMP_LO:   rd_data = mtimecmp[31:0];
      REG_CMP_HI:   rd_data = mtimecmp[63:32];
      default:      rd_data = 32'h0;
    endcase
  end

  // The prescaler runs freely. Bus traffic never restarts it.
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // always_ff block samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // A bus write to either half takes priority over the increment on the same edge.
  // That increment is dropped. The half that is not written keeps its old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= 64'h0;
    end else if (wr_en && (reg_sel == REG_MTIME_LO)) begin
      mtime[31:0] <= bus.tmr_dat_w;
    end else if (wr_en && (reg_sel == REG_MTIME_HI)) begin
      mtime[63:32] <= bus.tmr_dat_w;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_en && (reg_sel == REG_CMP_LO)) begin
      mtimecmp[31:0] <= bus.tmr_dat_w;
    end else if (wr_en && (reg_sel == REG_CMP_HI)) begin
      mtimecmp[63:32] <= bus.tmr_dat_w;
    end
  end

  // Read data is captured on the ack-rising edge from pre-edge values.
  // It then holds until the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tmr_ack   <= 1'b0;
      bus.tmr_dat_r <= 32'h0;
    end else begin
      bus.tmr_ack <= req;
      if (req) begin
        bus.tmr_dat_r <= rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_interrupt <= 1'b0;
    end else begin
      timer_interrupt <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer
//   Self-checking bench for wb_timer. Two instances share one bus stimulus:
//   dut0 uses PRESCALER=4 and dut1 uses PRESCALER=1.
//   The reference model counts edges since reset and derives ticks with modulo arithmetic.
//   It holds mtime and mtimecmp as plain 64-bit integers.
module tb_wb_timer;

  localparam int unsigned P0 = 4;
  localparam int unsigned P1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq0, irq1;

  wb_timer_if if0 ();
  wb_timer_if if1 ();

  wb_timer #(.PRESCALER(P0)) dut0 (.clk(clk), .rst(rst), .bus(if0), .timer_interrupt(irq0));
  wb_timer #(.PRESCALER(P1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .timer_interrupt(irq1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic            p_req = 1'b0;
  logic [1:0]      p_addr = 2'd0;
  logic            p_we = 1'b0;
  logic [3:0]      p_sel = 4'h0;
  logic [31:0]     p_dat = 32'h0;

  longint unsigned m_mtime [2];
  longint unsigned m_cmp   [2];
  int unsigned     m_n     [2];
  logic            m_irq   [2];
  logic [31:0]     snap    [2];

  function automatic int unsigned psc(input int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] a, input longint unsigned mt,
                                       input longint unsigned cp);
    case (a)
      2'd0:    return mt[31:0];
      2'd1:    return mt[63:32];
      2'd2:    return cp[31:0];
      default: return cp[63:32];
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_mtime[d] = 64'h0;
        m_cmp[d]   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_n[d]     = 0;
        m_irq[d]   = 1'b0;
        snap[d]    = 32'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        longint unsigned mt, cp;
        bit tk;
        mt = m_mtime[d];
        cp = m_cmp[d];
        if (p_req) snap[d] = pick(p_addr, mt, cp);
        m_irq[d] = (mt >= cp);
        tk = ((m_n[d] % psc(d)) == (psc(d) - 1));
        m_n[d] = m_n[d] + 1;
        if (tk) m_mtime[d] = mt + 64'd1;
        if (p_req && p_we && (p_sel == 4'hF)) begin
          case (p_addr)
            2'd0:    m_mtime[d] = {mt[63:32], p_dat};
            2'd1:    m_mtime[d] = {p_dat, mt[31:0]};
            2'd2:    m_cmp[d]   = {cp[63:32], p_dat};
            default: m_cmp[d]   = {p_dat, cp[31:0]};
          endcase
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare both interrupt lines with the model.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      check("irq0", 64'(irq0), 64'(m_irq[0]));
      check("irq1", 64'(irq1), 64'(m_irq[1]));
    end
  endtask

  task automatic drive_bus(input logic act, input logic we, input logic [1:0] addr,
                           input logic [3:0] sel, input logic [31:0] dat);
    logic [5:0] a;
    logic [2:0] cti;
    logic [1:0] bte;
    a   = {4'($urandom), addr};
    cti = 3'($urandom);
    bte = 2'($urandom);
    if0.tmr_cyc = act; if0.tmr_stb = act; if0.tmr_we = we; if0.tmr_addr = a;
    if0.tmr_sel = sel; if0.tmr_dat_w = dat; if0.tmr_cti = cti; if0.tmr_bte = bte;
    if1.tmr_cyc = act; if1.tmr_stb = act; if1.tmr_we = we; if1.tmr_addr = a;
    if1.tmr_sel = sel; if1.tmr_dat_w = dat; if1.tmr_cti = cti; if1.tmr_bte = bte;
  endtask

  // Run one single-beat transfer. On return the simulation sits at the falling edge
  // that follows the ack-rising (commit) edge.
  task automatic xfer(input logic [1:0] addr, input logic we, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rd0, output logic [31:0] rd1);
    step();
    drive_bus(1'b1, we, addr, sel, dat);
    p_req = 1'b1; p_addr = addr; p_we = we; p_sel = sel; p_dat = dat;
    step();
    p_req = 1'b0;
    check("ack0", 64'(if0.tmr_ack), 64'd1);
    check("ack1", 64'(if1.tmr_ack), 64'd1);
    check("err", 64'({if0.tmr_err, if1.tmr_err}), 64'd0);
    rd0 = if0.tmr_dat_r;
    rd1 = if1.tmr_dat_r;
    if (!we) begin
      check("rd0_model", 64'(rd0), 64'(snap[0]));
      check("rd1_model", 64'(rd1), 64'(snap[1]));
    end
    drive_bus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    drive_bus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] r0, r1;
    logic [5:0]  pat;
    int          k;

    vecs[0] = '{addr: 2'd2, we: 1'b1, sel: 4'hF, wdat: 32'h1234_5678, exp: 32'h0};
    vecs[1] = '{addr: 2'd2, we: 1'b0, sel: 4'hF, wdat: 32'h0,         exp: 32'h1234_5678};
    vecs[2] = '{addr: 2'd3, we: 1'b1, sel: 4'h3, wdat: 32'h0000_AAAA, exp: 32'h0};
    vecs[3] = '{addr: 2'd3, we: 1'b0, sel: 4'hF, wdat: 32'h0,         exp: 32'hFFFF_FFFF};
    vecs[4] = '{addr: 2'd3, we: 1'b1, sel: 4'hF, wdat: 32'hDEAD_BEEF, exp: 32'h0};
    vecs[5] = '{addr: 2'd3, we: 1'b0, sel: 4'hF, wdat: 32'h0,         exp: 32'hDEAD_BEEF};
    vecs[6] = '{addr: 2'd2, we: 1'b1, sel: 4'h8, wdat: 32'h0,         exp: 32'h0};
    vecs[7] = '{addr: 2'd2, we: 1'b0, sel: 4'hF, wdat: 32'h0,         exp: 32'h1234_5678};

    drive_bus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    do_reset();

    // Values right after reset.
    check("rst_ack", 64'({if0.tmr_ack, if1.tmr_ack}), 64'd0);
    check("rst_dat_r", 64'(if1.tmr_dat_r), 64'd0);
    check("rst_irq", 64'({irq0, irq1}), 64'd0);
    xfer(2'd0, 1'b0, 4'hF, 32'h0, r0, r1);
    check("rst_mtime_lo_p4", 64'(r0), 64'd0);
    xfer(2'd1, 1'b0, 4'hF, 32'h0, r0, r1);
    check("rst_mtime_hi", 64'({r0, r1}), 64'd0);
    xfer(2'd2, 1'b0, 4'hF, 32'h0, r0, r1);
    check("rst_cmp_lo", 64'({r0, r1}), 64'hFFFF_FFFF_FFFF_FFFF);
    xfer(2'd3, 1'b0, 4'hF, 32'h0, r0, r1);
    check("rst_cmp_hi", 64'({r0, r1}), 64'hFFFF_FFFF_FFFF_FFFF);

    // Table of mtimecmp register accesses, including partial-select writes.
    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i].addr, vecs[i].we, vecs[i].sel, vecs[i].wdat, r0, r1);
      if (!vecs[i].we) begin
        check($sformatf("vec%0d_rd0", i), 64'(r0), 64'(vecs[i].exp));
        check($sformatf("vec%0d_rd1", i), 64'(r1), 64'(vecs[i].exp));
      end
    end

    // PRESCALER=4: idle 40 cycles, then mtime lo should read about 10.
    do_reset();
    repeat (40) step();
    xfer(2'd0, 1'b0, 4'hF, 32'h0, r0, r1);
    check("p4_mtime_range", 64'((r0 >= 32'd9) && (r0 <= 32'd11)), 64'd1);

    // PRESCALER=1: interrupt rises 11 cycles after the mtime write.
    do_reset();
    xfer(2'd2, 1'b1, 4'hF, 32'd100, r0, r1);
    xfer(2'd3, 1'b1, 4'hF, 32'd0, r0, r1);
    xfer(2'd1, 1'b1, 4'hF, 32'd0, r0, r1);
    xfer(2'd0, 1'b1, 4'hF, 32'd90, r0, r1);
    check("irq_before_rise", 64'(irq1), 64'd0);
    k = 0;
    while (!irq1 && k < 20) begin
      step();
      k++;
    end
    check("irq_rise_cycles", 64'(k), 64'd11);
    // Raising mtimecmp drops the interrupt one cycle after the ack.
    xfer(2'd2, 1'b1, 4'hF, 32'd1000, r0, r1);
    check("irq_at_cmp_ack", 64'(irq1), 64'd1);
    step();
    check("irq_after_cmp_raise", 64'(irq1), 64'd0);

    // Carry from the low half into the high half.
    xfer(2'd1, 1'b1, 4'hF, 32'd0, r0, r1);
    xfer(2'd0, 1'b1, 4'hF, 32'hFFFF_FFFF, r0, r1);
    xfer(2'd1, 1'b0, 4'hF, 32'h0, r0, r1);
    check("carry_hi", 64'(r1), 64'd1);

    // 64-bit wrap clears the interrupt with cmp = 5.
    xfer(2'd3, 1'b1, 4'hF, 32'd0, r0, r1);
    xfer(2'd2, 1'b1, 4'hF, 32'd5, r0, r1);
    xfer(2'd1, 1'b1, 4'hF, 32'hFFFF_FFFF, r0, r1);
    xfer(2'd0, 1'b1, 4'hF, 32'hFFFF_FFFE, r0, r1);
    step();
    step();
    check("irq_before_wrap", 64'(irq1), 64'd1);
    step();
    check("irq_after_wrap", 64'(irq1), 64'd0);
    xfer(2'd1, 1'b0, 4'hF, 32'h0, r0, r1);
    check("wrap_hi", 64'(r1), 64'd0);

    // A partial-select write is acked without an error and leaves the value unchanged.
    xfer(2'd2, 1'b1, 4'b0011, 32'h0000_AAAA, r0, r1);
    xfer(2'd2, 1'b0, 4'hF, 32'h0, r0, r1);
    check("partial_cmp_lo", 64'({r0, r1}), {32'd5, 32'd5});

    // Under a continuous strobe, ack alternates.
    step();
    drive_bus(1'b1, 1'b0, 2'd0, 4'hF, 32'h0);
    pat[5] = if1.tmr_ack;
    for (int i = 4; i >= 0; i--) begin
      step();
      pat[i] = if1.tmr_ack;
    end
    check("ack_pattern", 64'(pat), 64'(6'b010101));
    drive_bus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);

    // Reset asserted while a write is being acked.
    step();
    drive_bus(1'b1, 1'b1, 2'd2, 4'hF, 32'd5);
    p_req = 1'b1; p_addr = 2'd2; p_we = 1'b1; p_sel = 4'hF; p_dat = 32'd5;
    step();
    p_req = 1'b0;
    check("rstmid_ack_before", 64'(if1.tmr_ack), 64'd1);
    #2 rst = 1'b1;
    #1 check("rstmid_ack_drop", 64'({if0.tmr_ack, if1.tmr_ack}), 64'd0);
    drive_bus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    xfer(2'd2, 1'b0, 4'hF, 32'h0, r0, r1);
    check("rstmid_cmp_lo", 64'({r0, r1}), 64'hFFFF_FFFF_FFFF_FFFF);
    xfer(2'd3, 1'b0, 4'hF, 32'h0, r0, r1);
    check("rstmid_cmp_hi", 64'({r0, r1}), 64'hFFFF_FFFF_FFFF_FFFF);

    // Random traffic compared against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = $urandom_range(0, 2000);
        2:       d = 32'hFFFF_FFFF;
        default: d = 32'h0;
      endcase
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      xfer(2'($urandom), 1'($urandom), s, d, r0, r1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
